multi_debouncer: RTL and testbench

Parametrised N-channel push-button debouncer for the elevator front panel. It replaces per-button single-channel debouncers. Each channel synchronises a raw button input, filters bounce with a programmable stable-count window, and exposes a debounced level. Each channel also produces registered one-cycle press, release and long-press pulses, which the floor-request and door-control logic consume.

---
 rtl/multi_debouncer.sv | 136 +++++++++++++
 tb/tb_multi_debouncer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_debouncer.sv
// -----------------------------------------------------------------------------
// multi_debouncer
// N independent push-button debouncers for the elevator front panel.
// Each channel synchronises its raw pin through two flops, requires DB_CYCLES
// consecutive disagreeing samples before accepting a new level, and emits
// registered one-cycle press / release / long-press pulses.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset, clears every flop
//   btn_raw      [N] raw asynchronous button pins (active-low when INVERT=1)
//   btn_level    [N] debounced pressed level (1 = pressed)
//   btn_press    [N] one-cycle pulse on accepted 0->1 of btn_level
//   btn_release  [N] one-cycle pulse on accepted 1->0 of btn_level
//   btn_long     [N] one-cycle pulse once per press after LONG_CYCLES held
//   any_press    OR of btn_press, aligned with the press pulses
// -----------------------------------------------------------------------------
module multi_debouncer #(
   parameter int N           = 4,
   parameter int DB_CYCLES   = 65536,
   parameter int LONG_CYCLES = 50000000,
   parameter bit INVERT      = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] btn_raw,
   output logic [N-1:0] btn_level,
   output logic [N-1:0] btn_press,
   output logic [N-1:0] btn_release,
   output logic [N-1:0] btn_long,
   output logic         any_press
);

   localparam int DBW = $clog2(DB_CYCLES + 1);
   localparam int HW  = $clog2(LONG_CYCLES + 1);

   localparam logic [DBW-1:0] DB_ZERO   = {DBW{1'b0}};
   localparam logic [DBW-1:0] DB_ONE    = DBW'(1);
   localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
   localparam logic [HW-1:0]  HOLD_ZERO = {HW{1'b0}};
   localparam logic [HW-1:0]  HOLD_ONE  = HW'(1);
   localparam logic [HW-1:0]  HOLD_LAST = HW'(LONG_CYCLES - 1);
   localparam logic [HW-1:0]  HOLD_MAX  = HW'(LONG_CYCLES);
   localparam logic [N-1:0]   INV_MASK  = {N{INVERT}};

   logic [N-1:0]   sync0_q;
   logic [N-1:0]   sync1_q;
   logic [N-1:0]   state_q;
   logic [N-1:0]   state_d;
   logic [DBW-1:0] db_cnt_q   [N];
   logic [DBW-1:0] db_cnt_d   [N];
   logic [HW-1:0]  hold_cnt_q [N];
   logic [HW-1:0]  hold_cnt_d [N];
   logic [N-1:0]   press_q;
   logic [N-1:0]   press_d;
   logic [N-1:0]   release_q;
   logic [N-1:0]   release_d;
   logic [N-1:0]   long_q;
   logic [N-1:0]   long_d;
   logic           any_q;
   logic           any_d;

   // Next-state logic for the debounce counters, levels, hold counters and pulses.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         state_d[i]    = state_q[i];
         db_cnt_d[i]   = DB_ZERO;
         hold_cnt_d[i] = hold_cnt_q[i];
         press_d[i]    = 1'b0;
         release_d[i]  = 1'b0;
         long_d[i]     = 1'b0;

         // Any agreeing sample (including a bounce) restarts the window.
         if (sync1_q[i] == state_q[i]) begin
            db_cnt_d[i] = DB_ZERO;
         end else if (db_cnt_q[i] == DB_LAST) begin
            state_d[i]   = sync1_q[i];
            db_cnt_d[i]  = DB_ZERO;
            press_d[i]   = sync1_q[i];
            release_d[i] = ~sync1_q[i];
         end else begin
            db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
         end

         // Saturating hold counter: stopping at HOLD_MAX limits btn_long to one pulse per press.
         if (!state_q[i]) begin
            hold_cnt_d[i] = HOLD_ZERO;
         end else if (hold_cnt_q[i] < HOLD_MAX) begin
            hold_cnt_d[i] = hold_cnt_q[i] + HOLD_ONE;
            long_d[i]     = (hold_cnt_q[i] == HOLD_LAST);
         end else begin
            hold_cnt_d[i] = hold_cnt_q[i];
         end
      end

      // Derived from the next-state pulses so it lands in the same cycle as btn_press.
      any_d = |press_d;
   end

   // All channel state: synchroniser, level, counters and registered pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync0_q   <= {N{1'b0}};
         sync1_q   <= {N{1'b0}};
         state_q   <= {N{1'b0}};
         press_q   <= {N{1'b0}};
         release_q <= {N{1'b0}};
         long_q    <= {N{1'b0}};
         any_q     <= 1'b0;
         for (int i = 0; i < N; i++) begin
            db_cnt_q[i]   <= DB_ZERO;
            hold_cnt_q[i] <= HOLD_ZERO;
         end
      end else begin
         // Polarity is normalised at the first stage so everything downstream is active-high.
         sync0_q   <= btn_raw ^ INV_MASK;
         sync1_q   <= sync0_q;
         state_q   <= state_d;
         press_q   <= press_d;
         release_q <= release_d;
         long_q    <= long_d;
         any_q     <= any_d;
         for (int i = 0; i < N; i++) begin
            db_cnt_q[i]   <= db_cnt_d[i];
            hold_cnt_q[i] <= hold_cnt_d[i];
         end
      end
   end

   assign btn_level   = state_q;
   assign btn_press   = press_q;
   assign btn_release = release_q;
   assign btn_long    = long_q;
   assign any_press   = any_q;

endmodule

// File: tb/tb_multi_debouncer.sv
// -----------------------------------------------------------------------------
// tb_multi_debouncer
// Directed bench for multi_debouncer with N=4, DB_CYCLES=4, LONG_CYCLES=10,
// INVERT=1. Inputs change 1 time unit after a rising edge; outputs are checked
// at the same point (reflecting the edge just passed). A negedge monitor counts
// pulses per channel and checks pulse invariants.
// -----------------------------------------------------------------------------
module tb_multi_debouncer;

   logic       clk;
   logic       rst_n;
   logic [3:0] btn_raw;
   logic [3:0] btn_level;
   logic [3:0] btn_press;
   logic [3:0] btn_release;
   logic [3:0] btn_long;
   logic       any_press;

   int n_checks = 0;
   int n_fail   = 0;
   int press_cnt   [4] = '{0, 0, 0, 0};
   int release_cnt [4] = '{0, 0, 0, 0};
   int long_cnt    [4] = '{0, 0, 0, 0};
   int rel_before;

   multi_debouncer #(
      .N           (4),
      .DB_CYCLES   (4),
      .LONG_CYCLES (10),
      .INVERT      (1'b1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_raw     (btn_raw),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .btn_long    (btn_long),
      .any_press   (any_press)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_level"},   8'(btn_level),   8'h00);
      chk({tag, "_press"},   8'(btn_press),   8'h00);
      chk({tag, "_release"}, 8'(btn_release), 8'h00);
      chk({tag, "_long"},    8'(btn_long),    8'h00);
      chk({tag, "_any"},     8'(any_press),   8'h00);
   endtask

   // Pulse counting and per-cycle invariants, sampled away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 4; i++) begin
            press_cnt[i]   += int'(btn_press[i]);
            release_cnt[i] += int'(btn_release[i]);
            long_cnt[i]    += int'(btn_long[i]);
         end
         n_checks++;
         assert ((btn_press & btn_release) === 4'b0000)
         else begin
            n_fail++;
            $error("FAIL press_release_overlap: observed %b expected 0000", btn_press & btn_release);
         end
         n_checks++;
         assert (any_press === (|btn_press))
         else begin
            n_fail++;
            $error("FAIL any_press_or: observed %b expected %b", any_press, |btn_press);
         end
      end
   end

   initial begin
      // Reset state
      rst_n   = 1'b0;
      btn_raw = 4'b1111;
      cyc(3);
      chk_all_zero("reset");
      rst_n = 1'b1;
      cyc(8);
      chk_all_zero("idle");

      // Clean press and release on channel 0
      btn_raw = 4'b1110;
      cyc(5);
      chk("p0_level_k4", 8'(btn_level), 8'h00);
      chk("p0_press_k4", 8'(btn_press), 8'h00);
      cyc(1);
      chk("p0_level_k5",   8'(btn_level),   8'h01);
      chk("p0_press_k5",   8'(btn_press),   8'h01);
      chk("p0_any_k5",     8'(any_press),   8'h01);
      chk("p0_release_k5", 8'(btn_release), 8'h00);
      cyc(1);
      chk("p0_press_k6", 8'(btn_press), 8'h00);
      chk("p0_any_k6",   8'(any_press), 8'h00);
      chk("p0_level_k6", 8'(btn_level), 8'h01);
      btn_raw = 4'b1111;
      cyc(5);
      chk("r0_level_k4",   8'(btn_level),   8'h01);
      chk("r0_release_k4", 8'(btn_release), 8'h00);
      cyc(1);
      chk("r0_release_k5", 8'(btn_release), 8'h01);
      chk("r0_level_k5",   8'(btn_level),   8'h00);
      chk("r0_any_k5",     8'(any_press),   8'h00);
      cyc(1);
      chk("r0_release_k6", 8'(btn_release), 8'h00);
      cyc(12);
      chk("p0_long_count", 8'(long_cnt[0]), 8'd0);

      // Bounce rejection on channel 1: 3 low, 1 high, 3 low, high
      btn_raw = 4'b1101;
      cyc(3);
      chk("b1_level_mid1", 8'(btn_level), 8'h00);
      btn_raw = 4'b1111;
      cyc(1);
      btn_raw = 4'b1101;
      cyc(3);
      chk("b1_level_mid2", 8'(btn_level), 8'h00);
      btn_raw = 4'b1111;
      cyc(10);
      chk("b1_level_end",  8'(btn_level),    8'h00);
      chk("b1_press_count", 8'(press_cnt[1]), 8'd0);
      // A clean press afterwards still needs the full window
      btn_raw = 4'b1101;
      cyc(5);
      chk("b1_clean_k4", 8'(btn_press), 8'h00);
      cyc(1);
      chk("b1_clean_k5", 8'(btn_press), 8'h02);
      btn_raw = 4'b1111;
      cyc(6);
      chk("b1_release_k5", 8'(btn_release), 8'h02);
      cyc(8);

      // Long press on channel 2: held 30 cycles
      btn_raw = 4'b1011;
      cyc(6);
      chk("l2_press",  8'(btn_press), 8'h04);
      chk("l2_level",  8'(btn_level), 8'h04);
      cyc(9);
      chk("l2_long_p9",  8'(btn_long), 8'h00);
      cyc(1);
      chk("l2_long_p10", 8'(btn_long), 8'h04);
      cyc(1);
      chk("l2_long_p11", 8'(btn_long), 8'h00);
      chk("l2_level_held", 8'(btn_level), 8'h04);
      cyc(13);
      btn_raw = 4'b1111;
      cyc(5);
      chk("l2_release_k4", 8'(btn_release), 8'h00);
      chk("l2_level_k4",   8'(btn_level),   8'h04);
      cyc(1);
      chk("l2_release_k5", 8'(btn_release), 8'h04);
      chk("l2_level_k5",   8'(btn_level),   8'h00);
      cyc(12);
      chk("l2_press_count",   8'(press_cnt[2]),   8'd1);
      chk("l2_long_count",    8'(long_cnt[2]),    8'd1);
      chk("l2_release_count", 8'(release_cnt[2]), 8'd1);

      // Short press on channel 3: held 8 cycles
      btn_raw = 4'b0111;
      cyc(6);
      chk("s3_press", 8'(btn_press), 8'h08);
      chk("s3_level", 8'(btn_level), 8'h08);
      cyc(2);
      btn_raw = 4'b1111;
      cyc(5);
      chk("s3_release_k4", 8'(btn_release), 8'h00);
      cyc(1);
      chk("s3_release_k5", 8'(btn_release), 8'h08);
      chk("s3_level_k5",   8'(btn_level),   8'h00);
      cyc(10);
      chk("s3_long_count",    8'(long_cnt[3]),    8'd0);
      chk("s3_press_count",   8'(press_cnt[3]),   8'd1);
      chk("s3_release_count", 8'(release_cnt[3]), 8'd1);

      // Simultaneous press on channels 0, 1, 3
      btn_raw = 4'b0100;
      cyc(5);
      chk("sim_press_k4", 8'(btn_press), 8'h00);
      cyc(1);
      chk("sim_press_k5", 8'(btn_press), 8'h0B);
      chk("sim_any_k5",   8'(any_press), 8'h01);
      chk("sim_level_k5", 8'(btn_level), 8'h0B);
      cyc(1);
      chk("sim_press_k6", 8'(btn_press), 8'h00);
      chk("sim_any_k6",   8'(any_press), 8'h00);
      btn_raw = 4'b1111;
      cyc(6);
      chk("sim_release_k5", 8'(btn_release), 8'h0B);
      chk("sim_release_any", 8'(any_press),  8'h00);
      chk("sim_level_rel",  8'(btn_level),   8'h00);
      cyc(1);
      chk("sim_release_k6", 8'(btn_release), 8'h00);
      cyc(8);

      // Reset mid-operation: channel 2 held high, channel 0 at debounce count 2
      btn_raw = 4'b1011;
      cyc(6);
      chk("rm_level2", 8'(btn_level), 8'h04);
      btn_raw = 4'b1010;
      cyc(4);
      rel_before = release_cnt[2];
      rst_n = 1'b0;
      #1;
      chk_all_zero("rm_assert");
      cyc(3);
      chk_all_zero("rm_hold");
      rst_n = 1'b1;
      cyc(5);
      chk("rm_press_k4", 8'(btn_press), 8'h00);
      chk("rm_level_k4", 8'(btn_level), 8'h00);
      cyc(1);
      chk("rm_press_k5", 8'(btn_press), 8'h05);
      chk("rm_level_k5", 8'(btn_level), 8'h05);
      chk("rm_any_k5",   8'(any_press), 8'h01);
      cyc(1);
      chk("rm_press_k6", 8'(btn_press), 8'h00);
      cyc(4);
      chk("rm_no_release", 8'(release_cnt[2] - rel_before), 8'd0);

      btn_raw = 4'b1111;
      cyc(10);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
